// File: rtl/gen_step_ctrl_pkg.sv
// Shared definitions for the Game-of-Life generation step controller.
//   state_t         : controller FSM states (IDLE, READ, WAIT, WRITE)
//   NBR_*           : read index of each neighbour in the per-cell read burst,
//                     NBR_CENTRE being the last read of the burst
//   READS_PER_CELL  : number of memory reads issued for every cell
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [3:0] NBR_NW     = 4'd0;
    localparam logic [3:0] NBR_N      = 4'd1;
    localparam logic [3:0] NBR_NE     = 4'd2;
    localparam logic [3:0] NBR_W      = 4'd3;
    localparam logic [3:0] NBR_E      = 4'd4;
    localparam logic [3:0] NBR_SW     = 4'd5;
    localparam logic [3:0] NBR_S      = 4'd6;
    localparam logic [3:0] NBR_SE     = 4'd7;
    localparam logic [3:0] NBR_CENTRE = 4'd8;

    localparam logic [3:0] READS_PER_CELL = 4'd9;

endpackage

// File: rtl/gen_step_ctrl_if.sv
// Memory-side bus of the generation step controller.
//   o_rd_en / o_rd_addr : read request to the current-generation memory
//   i_rd_data           : cell state returned one cycle after o_rd_en
//   o_wr_en / o_wr_addr / o_wr_data : write to the next-generation memory
// Modports: master = controller side, slave = memory side.
interface gen_step_ctrl_if #(
    parameter int GRID_W = 64,
    parameter int GRID_H = 48
);
    localparam int ADDR_W = $clog2(GRID_W * GRID_H);

    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              i_rd_data;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic              o_wr_data;

    modport master (
        output o_rd_en,
        output o_rd_addr,
        input  i_rd_data,
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data
    );

    modport slave (
        input  o_rd_en,
        input  o_rd_addr,
        output i_rd_data,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data
    );

endinterface

// File: rtl/gen_step_ctrl_next_cell.sv
// Life rule for a single cell.
//   i_nbrs       : 8 neighbour states
//   i_cell_state : current state of the cell
//   o_cell_state : next state (survive on 2 or 3 neighbours, birth on 3)
module next_cell_state (
    input  logic [7:0] i_nbrs,
    input  logic       i_cell_state,
    output logic       o_cell_state
);

    logic [3:0] live;

    always_comb begin
        live = '0;
        for (int i = 0; i < 8; i++) begin
            live = live + {3'b000, i_nbrs[i]};
        end
        o_cell_state = (live == 4'd3) || (i_cell_state && (live == 4'd2));
    end

endmodule

// File: rtl/gen_step_ctrl.sv
// Computes one Game-of-Life generation over a toroidal GRID_W x GRID_H grid.
// Cells are visited in raster order; for each cell the 8 neighbours and then
// the centre are read (9 cycles), one cycle waits for the last read data, and
// one cycle writes the new state: 11 cycles per cell.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : request one generation (ignored while busy)
//   o_busy         : generation in progress
//   o_done         : one-cycle pulse after the last cell is written
//   o_gen_count    : completed generations, wraps at 16 bits
//   mem            : read/write memory bus (gen_step_ctrl_if master)
module gen_step_ctrl
    import gol_pkg::*;
#(
    parameter int GRID_W = 64,
    parameter int GRID_H = 48
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_gen_count,
    gen_step_ctrl_if.master mem
);

    localparam int ADDR_W = $clog2(GRID_W * GRID_H);
    localparam int XW     = $clog2(GRID_W);
    localparam int YW     = $clog2(GRID_H);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    state_t state;
    state_t state_next;

    logic [XW-1:0] cell_x;
    logic [YW-1:0] cell_y;
    logic [3:0]    rd_idx;
    logic          last_cell;
    logic          last_read;

    // Tracks which read index the data arriving this cycle belongs to.
    logic          cap_vld;
    logic [3:0]    cap_idx;

    logic [7:0]    nbrs;
    logic          centre;
    logic          rule_out;

    logic          done_q;
    logic [15:0]   gen_count_q;

    logic [XW-1:0] x_dec, x_inc, rd_x;
    logic [YW-1:0] y_dec, y_inc, rd_y;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cell_addr;
    logic          rd_en;
    logic          wr_en;

    assign last_cell = (cell_x == X_MAX) && (cell_y == Y_MAX);
    assign last_read = (rd_idx == READS_PER_CELL - 4'd1);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = READ;
            READ:    if (last_read) state_next = WAIT;
            WAIT:    state_next = WRITE;
            WRITE:   state_next = last_cell ? IDLE : READ;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Control counters ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cell_x      <= '0;
            cell_y      <= '0;
            rd_idx      <= '0;
            cap_vld     <= 1'b0;
            cap_idx     <= '0;
            done_q      <= 1'b0;
            gen_count_q <= '0;
        end else begin
            cap_vld <= (state == READ);
            cap_idx <= rd_idx;
            done_q  <= (state == WRITE) && last_cell;
            if ((state == WRITE) && last_cell) begin
                gen_count_q <= gen_count_q + 16'd1;
            end
            case (state)
                IDLE: begin
                    cell_x <= '0;
                    cell_y <= '0;
                    rd_idx <= '0;
                end
                READ: begin
                    rd_idx <= last_read ? 4'd0 : rd_idx + 4'd1;
                end
                WRITE: begin
                    // After the last cell the IDLE state re-zeroes x/y.
                    if (!last_cell) begin
                        if (cell_x == X_MAX) begin
                            cell_x <= '0;
                            cell_y <= cell_y + YW'(1);
                        end else begin
                            cell_x <= cell_x + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Read data capture ----------------
    always_ff @(posedge i_clk) begin
        if (cap_vld) begin
            if (cap_idx == NBR_CENTRE) begin
                centre <= mem.i_rd_data;
            end else begin
                nbrs[cap_idx[2:0]] <= mem.i_rd_data;
            end
        end
    end

    // ---------------- Toroidal neighbour address ----------------
    assign x_dec = (cell_x == '0)  ? X_MAX : cell_x - XW'(1);
    assign x_inc = (cell_x == X_MAX) ? '0  : cell_x + XW'(1);
    assign y_dec = (cell_y == '0)  ? Y_MAX : cell_y - YW'(1);
    assign y_inc = (cell_y == Y_MAX) ? '0  : cell_y + YW'(1);

    always_comb begin
        rd_x = cell_x;
        rd_y = cell_y;
        case (rd_idx)
            NBR_NW:  begin rd_x = x_dec; rd_y = y_dec; end
            NBR_N:   rd_y = y_dec;
            NBR_NE:  begin rd_x = x_inc; rd_y = y_dec; end
            NBR_W:   rd_x = x_dec;
            NBR_E:   rd_x = x_inc;
            NBR_SW:  begin rd_x = x_dec; rd_y = y_inc; end
            NBR_S:   rd_y = y_inc;
            NBR_SE:  begin rd_x = x_inc; rd_y = y_inc; end
            default: ;
        endcase
    end

    assign rd_addr   = ADDR_W'(rd_y) * ADDR_W'(GRID_W) + ADDR_W'(rd_x);
    assign cell_addr = ADDR_W'(cell_y) * ADDR_W'(GRID_W) + ADDR_W'(cell_x);

    next_cell_state u_rule (
        .i_nbrs       (nbrs),
        .i_cell_state (centre),
        .o_cell_state (rule_out)
    );

    // ---------------- Outputs ----------------
    // Addresses and write data are forced to zero while their strobe is low
    // so the bus is quiet in IDLE and right after reset.
    assign rd_en         = (state == READ);
    assign wr_en         = (state == WRITE);
    assign mem.o_rd_en   = rd_en;
    assign mem.o_rd_addr = rd_en ? rd_addr : '0;
    assign mem.o_wr_en   = wr_en;
    assign mem.o_wr_addr = wr_en ? cell_addr : '0;
    assign mem.o_wr_data = wr_en & rule_out;

    assign o_busy      = (state != IDLE);
    assign o_done      = done_q;
    assign o_gen_count = gen_count_q;

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Self-checking bench for gen_step_ctrl on a 5x5 torus with 1-cycle memory models.
module tb_gen_step_ctrl;

    localparam int W        = 5;
    localparam int H        = 5;
    localparam int N        = W * H;
    localparam int CELL_CYC = 11;
    localparam int GEN_CYC  = 1 + N * CELL_CYC;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    gen_step_ctrl_if #(.GRID_W(W), .GRID_H(H)) mem ();

    gen_step_ctrl #(.GRID_W(W), .GRID_H(H)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_gen_count (gen_count),
        .mem         (mem)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory models: current generation read side, next generation write side.
    logic [N-1:0] cur_mem, nxt_mem, load_val;
    logic         load_en = 1'b0;

    always @(posedge clk) begin
        if (load_en) begin
            cur_mem <= load_val;
            nxt_mem <= '0;
        end else begin
            if (mem.o_rd_en) mem.i_rd_data <= cur_mem[mem.o_rd_addr];
            if (mem.o_wr_en) nxt_mem[mem.o_wr_addr] <= mem.o_wr_data;
            if (done) cur_mem <= nxt_mem;
        end
    end

    // Monitor
    int   cyc = 0;
    int   busy_cycles = 0;
    int   overlap = 0;
    int   rd_addr_q[$];
    int   wr_addr_q[$];
    int   wr_cyc_q[$];
    int   done_cyc_q[$];
    logic done_busy_q[$];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (busy) busy_cycles = busy_cycles + 1;
        if (mem.o_rd_en && mem.o_wr_en) overlap = overlap + 1;
        if (mem.o_rd_en) rd_addr_q.push_back(int'(mem.o_rd_addr));
        if (mem.o_wr_en) begin
            wr_addr_q.push_back(int'(mem.o_wr_addr));
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cyc_q.push_back(cyc);
            done_busy_q.push_back(busy);
        end
    end

    // Reference model
    function automatic int idx(input int x, input int y);
        return y * W + x;
    endfunction

    function automatic logic [N-1:0] life_step(input logic [N-1:0] g);
        logic [N-1:0] r;
        int cnt;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (!(dx == 0 && dy == 0))
                            cnt += int'(g[idx((x + dx + W) % W, (y + dy + H) % H)]);
                r[idx(x, y)] = (cnt == 3) || (g[idx(x, y)] && cnt == 2);
            end
        end
        return r;
    endfunction

    task automatic load_grid(input logic [N-1:0] g);
        @(negedge clk);
        load_val = g;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Pulses start and waits (bounded) for done; leaves time at the done negedge.
    task automatic run_gen(output int start_cyc, output bit ok);
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < GEN_CYC + 50 && !ok; i++) begin
            if (done) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (mem.o_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%0b exp=0", mem.o_rd_en); end
        checks++; if (mem.o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0b exp=0", mem.o_wr_en); end
        checks++; if (mem.o_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", mem.o_rd_addr); end
        checks++; if (mem.o_wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", mem.o_wr_addr); end
        checks++; if (mem.o_wr_data !== 1'b0) begin errors++; $display("FAIL reset_wr_data got=%0b exp=0", mem.o_wr_data); end
        checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen_count got=%0d exp=0", gen_count); end
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_blinker;
        logic [N-1:0] g, exp;
        int s; bit ok; int dbase;
        g = '0;
        g[idx(1, 2)] = 1'b1; g[idx(2, 2)] = 1'b1; g[idx(3, 2)] = 1'b1;
        exp = '0;
        exp[idx(2, 1)] = 1'b1; exp[idx(2, 2)] = 1'b1; exp[idx(2, 3)] = 1'b1;
        load_grid(g);
        dbase = done_cyc_q.size();
        run_gen(s, ok);
        checks++; if (!ok) begin errors++; $display("FAIL blinker_timeout got=no_done exp=done"); end
        checks++; if (nxt_mem !== exp) begin errors++; $display("FAIL blinker_grid got=%h exp=%h", nxt_mem, exp); end
        checks++; if (gen_count !== 16'd1) begin errors++; $display("FAIL blinker_gen_count got=%0d exp=1", gen_count); end
        checks++;
        if (done_busy_q.size() <= dbase || done_busy_q[dbase] !== 1'b0) begin
            errors++; $display("FAIL blinker_busy_at_done got=busy_or_missing exp=0");
        end
    endtask

    task automatic test_timing;
        logic [N-1:0] g;
        int s; bit ok; int wbase, rbase, dbase, bbase, bad, nw;
        g = N'($urandom());
        load_grid(g);
        wbase = wr_addr_q.size(); rbase = rd_addr_q.size();
        dbase = done_cyc_q.size(); bbase = busy_cycles;
        run_gen(s, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timing_timeout got=no_done exp=done"); end
        checks++;
        if (done_cyc_q.size() <= dbase || done_cyc_q[dbase] - s != GEN_CYC) begin
            errors++; $display("FAIL timing_done_latency got=%0d exp=%0d",
                               (done_cyc_q.size() > dbase) ? done_cyc_q[dbase] - s : -1, GEN_CYC);
        end
        nw = wr_addr_q.size() - wbase;
        checks++; if (nw != N) begin errors++; $display("FAIL timing_wr_count got=%0d exp=%0d", nw, N); end
        bad = 0;
        for (int i = 0; i < N && i < nw; i++)
            if (wr_addr_q[wbase + i] != i || wr_cyc_q[wbase + i] != s + CELL_CYC * (i + 1)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL timing_wr_order got=%0d_bad exp=0_bad", bad); end
        checks++;
        if (rd_addr_q.size() - rbase != N * 9) begin
            errors++; $display("FAIL timing_rd_count got=%0d exp=%0d", rd_addr_q.size() - rbase, N * 9);
        end
        checks++;
        if (busy_cycles - bbase != N * CELL_CYC) begin
            errors++; $display("FAIL timing_busy_cycles got=%0d exp=%0d", busy_cycles - bbase, N * CELL_CYC);
        end
        checks++; if (nxt_mem !== life_step(g)) begin errors++; $display("FAIL timing_grid got=%h exp=%h", nxt_mem, life_step(g)); end
    endtask

    task automatic test_wrap;
        logic [N-1:0] g;
        int exp_rd[9];
        int s; bit ok; int rbase, bad;
        exp_rd = '{24, 20, 21, 4, 1, 9, 5, 6, 0};
        g = '0;
        g[idx(4, 4)] = 1'b1; g[idx(0, 4)] = 1'b1; g[idx(4, 0)] = 1'b1;
        load_grid(g);
        rbase = rd_addr_q.size();
        run_gen(s, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got=no_done exp=done"); end
        checks++; if (nxt_mem[0] !== 1'b1) begin errors++; $display("FAIL wrap_birth got=%0b exp=1", nxt_mem[0]); end
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (rd_addr_q.size() <= rbase + i || rd_addr_q[rbase + i] != exp_rd[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_rd_addrs got=%0d_bad exp=0_bad", bad); end
        checks++; if (nxt_mem !== life_step(g)) begin errors++; $display("FAIL wrap_grid got=%h exp=%h", nxt_mem, life_step(g)); end
    endtask

    task automatic test_random;
        logic [N-1:0] g;
        int s; bit ok; logic [15:0] gc0;
        for (int t = 0; t < 3; t++) begin
            g = N'($urandom());
            gc0 = gen_count;
            load_grid(g);
            run_gen(s, ok);
            checks++; if (!ok) begin errors++; $display("FAIL random_timeout got=no_done exp=done"); end
            checks++; if (nxt_mem !== life_step(g)) begin errors++; $display("FAIL random_grid got=%h exp=%h", nxt_mem, life_step(g)); end
            checks++; if (gen_count !== gc0 + 16'd1) begin errors++; $display("FAIL random_gen_count got=%0d exp=%0d", gen_count, gc0 + 16'd1); end
        end
    endtask

    task automatic test_ignore_start;
        logic [N-1:0] g;
        int s, dbase; logic [15:0] gc0;
        g = N'($urandom());
        gc0 = gen_count;
        load_grid(g);
        dbase = done_cyc_q.size();
        @(negedge clk); start = 1'b1; s = cyc;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (GEN_CYC + 300) @(negedge clk);
        checks++;
        if (done_cyc_q.size() - dbase != 1) begin
            errors++; $display("FAIL ignore_done_count got=%0d exp=1", done_cyc_q.size() - dbase);
        end
        checks++;
        if (done_cyc_q.size() <= dbase || done_cyc_q[dbase] - s != GEN_CYC) begin
            errors++; $display("FAIL ignore_done_latency got=%0d exp=%0d",
                               (done_cyc_q.size() > dbase) ? done_cyc_q[dbase] - s : -1, GEN_CYC);
        end
        checks++; if (gen_count !== gc0 + 16'd1) begin errors++; $display("FAIL ignore_gen_count got=%0d exp=%0d", gen_count, gc0 + 16'd1); end
    endtask

    task automatic test_abort;
        logic [N-1:0] g;
        int s; bit ok; int wbase, dbase;
        g = N'($urandom());
        load_grid(g);
        @(negedge clk); start = 1'b1; s = cyc;
        @(negedge clk); start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        wbase = wr_addr_q.size();
        dbase = done_cyc_q.size();
        @(negedge clk); rst = 1'b0;
        repeat (GEN_CYC + 20) @(negedge clk);
        checks++; if (wr_addr_q.size() != wbase) begin errors++; $display("FAIL abort_writes got=%0d exp=0", wr_addr_q.size() - wbase); end
        checks++; if (done_cyc_q.size() != dbase) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_cyc_q.size() - dbase); end
        checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL abort_gen_count got=%0d exp=0", gen_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        load_grid(g);
        run_gen(s, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout got=no_done exp=done"); end
        checks++; if (nxt_mem !== life_step(g)) begin errors++; $display("FAIL abort_restart_grid got=%h exp=%h", nxt_mem, life_step(g)); end
        checks++; if (gen_count !== 16'd1) begin errors++; $display("FAIL abort_restart_gen_count got=%0d exp=1", gen_count); end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] g, model, shifted;
        int s, gens, prev; logic [15:0] gc0;
        g = '0;
        g[idx(1, 0)] = 1'b1; g[idx(2, 1)] = 1'b1;
        g[idx(0, 2)] = 1'b1; g[idx(1, 2)] = 1'b1; g[idx(2, 2)] = 1'b1;
        shifted = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (g[idx(x, y)]) shifted[idx((x + 1) % W, (y + 1) % H)] = 1'b1;
        model = g;
        gc0 = gen_count;
        load_grid(g);
        @(negedge clk); start = 1'b1; s = cyc;
        prev = s;
        gens = 0;
        for (int i = 0; i < 4 * GEN_CYC + 100 && gens < 4; i++) begin
            @(negedge clk);
            if (done) begin
                gens++;
                model = life_step(model);
                if (gens == 4) start = 1'b0;
                checks++;
                if (cyc - prev != GEN_CYC) begin
                    errors++; $display("FAIL b2b_interval gen=%0d got=%0d exp=%0d", gens, cyc - prev, GEN_CYC);
                end
                checks++;
                if (nxt_mem !== model) begin
                    errors++; $display("FAIL b2b_grid gen=%0d got=%h exp=%h", gens, nxt_mem, model);
                end
                prev = cyc;
            end
        end
        start = 1'b0;
        checks++; if (gens != 4) begin errors++; $display("FAIL b2b_gen_total got=%0d exp=4", gens); end
        checks++; if (nxt_mem !== shifted) begin errors++; $display("FAIL b2b_glider_shift got=%h exp=%h", nxt_mem, shifted); end
        checks++; if (gen_count !== gc0 + 16'd4) begin errors++; $display("FAIL b2b_gen_count got=%0d exp=%0d", gen_count, gc0 + 16'd4); end
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got=%0b exp=0", busy); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_blinker();
        test_timing();
        test_wrap();
        test_random();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        checks++; if (overlap != 0) begin errors++; $display("FAIL rd_wr_overlap got=%0d exp=0", overlap); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gen_step_ctrl.md
GEN_STEP_CTRL -- requirements
Module: gen_step_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 64, grid width in cells (>=3).
REQ-002 SHALL have parameter GRID_H, default 48, grid height in cells (>=3).
REQ-003 SHALL have localparam ADDR_W = $clog2(GRID_W*GRID_H), and cell (x,y) SHALL map to address y*GRID_W+x.
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  one-cycle request to compute one generation.
REQ-007 o_busy  out  1  high while a generation is being computed.
REQ-008 o_done  out  1  one-cycle pulse when a generation completes.
REQ-009 o_rd_en  out  1  read strobe to the current-generation memory.
REQ-010 o_rd_addr  out  ADDR_W  read address.
REQ-011 i_rd_data  in  1  cell state, valid the cycle after o_rd_en (fixed 1-cycle latency).
REQ-012 o_wr_en / o_wr_addr / o_wr_data  out  1/ADDR_W/1  write port to the next-generation memory.
REQ-013 o_gen_count  out  16  number of completed generations.

Function
REQ-014 SHALL use FSM states IDLE, READ, WAIT, WRITE; IDLE->READ on i_start, READ->WAIT after 9 reads, WAIT->WRITE, WRITE->READ for the next cell, or ->IDLE after the last cell.
REQ-015 SHALL visit cells in raster order from (0,0): x increments first, then y.
REQ-016 In READ, SHALL issue exactly 9 reads on consecutive cycles, k=0..7 neighbours NW,N,NE,W,E,SW,S,SE, then k=8 the centre cell.
REQ-017 SHALL compute neighbour coordinates toroidally: x-1 of 0 is GRID_W-1, x+1 of GRID_W-1 is 0, and y likewise with GRID_H.
REQ-018 SHALL capture the data for read k into neighbour bit k (k=0..7) and the centre read into the cell-state register.
REQ-019 SHALL form o_wr_data from the Life rule: survive on 2 or 3 neighbours, birth on exactly 3, otherwise dead.
REQ-020 In WRITE, SHALL assert o_wr_en for exactly one cycle with o_wr_addr equal to the current cell address.
REQ-021 Latency per cell SHALL be exactly 11 cycles; a generation SHALL take GRID_W*GRID_H*11 cycles from the first READ cycle to the last WRITE.
REQ-022 o_busy SHALL be high from the cycle after i_start is accepted through the last WRITE cycle.
REQ-023 o_done SHALL pulse in the cycle after the last WRITE, with o_busy low in that cycle.
REQ-024 SHALL ignore i_start while o_busy is high, and SHALL accept i_start in the same cycle o_done is high.
REQ-025 o_gen_count SHALL increment in the cycle o_done is high, and SHALL wrap from 65535 to 0.
REQ-026 o_rd_en SHALL be low outside READ, and o_wr_en SHALL be low outside WRITE.

Reset
REQ-027 On i_rst, SHALL enter IDLE with o_busy=0, o_done=0, o_rd_en=0, o_wr_en=0, addresses=0, o_wr_data=0 and o_gen_count=0.
REQ-028 i_rst mid-generation SHALL abort at once with no further writes, and SHALL not pulse o_done.
REQ-029 i_rst SHALL take priority over i_start in the same cycle.

Structure
REQ-030 Package gol_pkg SHALL hold the FSM state typedef, neighbour-index localparams (NBR_NW..NBR_SE = 0..7, NBR_CENTRE = 8) and READS_PER_CELL=9.
REQ-031 SHALL instantiate exactly one next_cell_state (i_nbrs, i_cell_state, o_cell_state) as its only sub-module, and SHALL not duplicate the rule logic.
REQ-032 Coordinate wrap SHALL use compare-and-select logic, with no divider or modulo operator.

Verification (GRID_W=5, GRID_H=5, 1-cycle-latency memory models)
REQ-033 Blinker: cells (1,2),(2,2),(3,2) alive, pulse i_start -> after done, alive exactly (2,1),(2,2),(2,3); o_gen_count=1.
REQ-034 Timing: i_start at cycle 0 -> o_done exactly 276 cycles later (1 + 25*11), with 25 o_wr_en pulses at addresses 0..24 in order.
REQ-035 Wrap: cells (4,4),(0,4),(4,0) alive -> (0,0) born, and the read addresses for cell (0,0) are 24,20,21,4,1,9,5,6,0.
REQ-036 Abort: i_rst at cycle 100 of a generation -> no o_wr_en, no o_done, o_gen_count=0, and a restart completes normally.
REQ-037 Back-to-back: i_start held high throughout -> o_done pulses every 276 cycles with no missed generation, and a glider returns to its shape shifted (+1,+1) mod 5 after 4 generations.
